// File: rtl/vz_file_loader.sv
// Parses a .vz ioctl stream (24-byte header) and writes the payload to RAM from the header start address.
// One write in flight: ioctl_wait follows mem_wr in DATA. BASIC (type F0) images also get the end-of-program pointer patched.
module vz_file_loader #(
    parameter logic [7:0]  VZ_INDEX      = 8'h01,
    parameter int          HDR_LEN       = 24,
    parameter logic [15:0] BASIC_END_PTR = 16'h78F9,
    parameter bit          CHECK_MAGIC   = 1'b1
) (
    input  logic        clk_50,
    input  logic        reset,
    input  logic        ioctl_download,
    input  logic [7:0]  ioctl_index,
    input  logic        ioctl_wr,
    input  logic [7:0]  ioctl_dout,
    output logic        ioctl_wait,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_data,
    output logic        mem_wr,
    input  logic        mem_ack,
    output logic        busy,
    output logic        load_done,
    output logic [7:0]  load_type,
    output logic [15:0] start_addr,
    output logic [15:0] end_addr,
    output logic [2:0]  err
);

    typedef enum logic [2:0] {IDLE, HDR, DATA, PTR_LO, PTR_HI, DONE, SKIP} state_t;

    localparam logic [4:0] HDR_LAST = 5'(HDR_LEN - 1);
    localparam logic [4:0] TYPE_POS = 5'(HDR_LEN - 3);
    localparam logic [4:0] LO_POS   = 5'(HDR_LEN - 2);

    state_t      r_state;
    state_t      w_next;
    logic        r_dl_q;
    logic [4:0]  r_hdr_cnt;
    logic        r_mem_wr;
    logic [15:0] r_mem_addr;
    logic [7:0]  r_mem_data;
    logic [7:0]  r_load_type;
    logic [15:0] r_start_addr;
    logic [15:0] r_end_addr;
    logic [2:0]  r_err;

    logic        w_dl_rise;
    logic        w_ack;
    logic [7:0]  w_magic_exp;
    logic        w_magic_bad;
    logic        w_start;
    logic        w_hdr_byte;
    logic        w_short;
    logic        w_take;
    logic        w_drop;

    assign w_dl_rise = ioctl_download & ~r_dl_q;
    assign w_ack     = r_mem_wr & mem_ack;

    always_comb begin
        w_magic_exp = 8'h00;
        case (r_hdr_cnt[1:0])
            2'd0:    w_magic_exp = 8'h56;
            2'd1:    w_magic_exp = 8'h5A;
            2'd2:    w_magic_exp = 8'h46;
            default: w_magic_exp = 8'h00;
        endcase
    end

    assign w_magic_bad = CHECK_MAGIC && (r_hdr_cnt < 5'd3) && (ioctl_dout != w_magic_exp);

    always_ff @(posedge clk_50 or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next     = r_state;
        w_start    = 1'b0;
        w_hdr_byte = 1'b0;
        w_short    = 1'b0;
        w_take     = 1'b0;
        w_drop     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_dl_rise && ioctl_index == VZ_INDEX) begin
                    w_next  = HDR;
                    w_start = 1'b1;
                end
            end
            HDR: begin
                if (!ioctl_download) begin
                    w_next  = IDLE;
                    w_short = 1'b1;
                end else if (ioctl_wr) begin
                    w_hdr_byte = 1'b1;
                    if (w_magic_bad)                w_next = SKIP;
                    else if (r_hdr_cnt == HDR_LAST) w_next = DATA;
                end
            end
            DATA: begin
                // A pending write always drains before the end of download is honoured.
                if (r_mem_wr) begin
                    w_drop = ioctl_wr;
                end else if (!ioctl_download) begin
                    w_next = (r_load_type == 8'hF0) ? PTR_LO : DONE;
                end else begin
                    w_take = ioctl_wr;
                end
            end
            PTR_LO:  if (mem_ack) w_next = PTR_HI;
            PTR_HI:  if (mem_ack) w_next = DONE;
            DONE:    w_next = IDLE;
            SKIP:    if (!ioctl_download) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_50 or posedge reset) begin
        if (reset) begin
            r_dl_q       <= 1'b0;
            r_hdr_cnt    <= 5'd0;
            r_mem_wr     <= 1'b0;
            r_mem_addr   <= 16'h0000;
            r_mem_data   <= 8'h00;
            r_load_type  <= 8'h00;
            r_start_addr <= 16'h0000;
            r_end_addr   <= 16'h0000;
            r_err        <= 3'b000;
        end else begin
            r_dl_q <= ioctl_download;
            if (w_start) begin
                r_err     <= 3'b000;
                r_hdr_cnt <= 5'd0;
            end
            if (w_hdr_byte) begin
                r_hdr_cnt <= r_hdr_cnt + 5'd1;
                if (w_magic_bad)           r_err[0] <= 1'b1;
                if (r_hdr_cnt == TYPE_POS) r_load_type <= ioctl_dout;
                if (r_hdr_cnt == LO_POS)   r_start_addr[7:0] <= ioctl_dout;
                if (r_hdr_cnt == HDR_LAST) begin
                    r_start_addr[15:8] <= ioctl_dout;
                    r_mem_addr         <= {ioctl_dout, r_start_addr[7:0]};
                    r_end_addr         <= {ioctl_dout, r_start_addr[7:0]};
                end
            end
            if (w_short) r_err[1] <= 1'b1;
            if (w_drop)  r_err[2] <= 1'b1;
            if (w_take) begin
                r_mem_data <= ioctl_dout;
                r_mem_wr   <= 1'b1;
            end
            if (r_state == DATA && w_ack) begin
                r_mem_wr   <= 1'b0;
                r_mem_addr <= r_mem_addr + 16'd1;
                r_end_addr <= r_mem_addr + 16'd1;
            end
            if (r_state == DATA && w_next == PTR_LO) begin
                r_mem_addr <= BASIC_END_PTR;
                r_mem_data <= r_end_addr[7:0];
                r_mem_wr   <= 1'b1;
            end
            if (r_state == PTR_LO && w_ack) begin
                r_mem_addr <= BASIC_END_PTR + 16'd1;
                r_mem_data <= r_end_addr[15:8];
            end
            if (r_state == PTR_HI && w_ack) r_mem_wr <= 1'b0;
        end
    end

    assign mem_wr     = r_mem_wr;
    assign ioctl_wait = r_mem_wr && (r_state == DATA);
    assign mem_addr   = r_mem_addr;
    assign mem_data   = r_mem_data;
    assign busy       = (r_state != IDLE);
    assign load_done  = (r_state == DONE);
    assign load_type  = r_load_type;
    assign start_addr = r_start_addr;
    assign end_addr   = r_end_addr;
    assign err        = r_err;

endmodule

// File: tb/tb_vz_file_loader.sv
// Directed bench for vz_file_loader with a RAM responder that acks after a programmable delay.
module tb_vz_file_loader;

    logic        clk_50 = 1'b0;
    logic        reset;
    logic        ioctl_download;
    logic [7:0]  ioctl_index;
    logic        ioctl_wr;
    logic [7:0]  ioctl_dout;
    logic        ioctl_wait;
    logic [15:0] mem_addr;
    logic [7:0]  mem_data;
    logic        mem_wr;
    logic        mem_ack;
    logic        busy;
    logic        load_done;
    logic [7:0]  load_type;
    logic [15:0] start_addr;
    logic [15:0] end_addr;
    logic [2:0]  err;

    vz_file_loader dut (
        .clk_50(clk_50), .reset(reset),
        .ioctl_download(ioctl_download), .ioctl_index(ioctl_index),
        .ioctl_wr(ioctl_wr), .ioctl_dout(ioctl_dout), .ioctl_wait(ioctl_wait),
        .mem_addr(mem_addr), .mem_data(mem_data), .mem_wr(mem_wr), .mem_ack(mem_ack),
        .busy(busy), .load_done(load_done), .load_type(load_type),
        .start_addr(start_addr), .end_addr(end_addr), .err(err)
    );

    always #5 clk_50 = ~clk_50;

    int checks = 0;
    int errors = 0;
    int ack_delay = 0;
    int ack_cnt = 0;
    int done_cnt = 0;
    int base;
    int dbase;
    logic [15:0] wa[$];
    logic [7:0]  wd[$];

    // RAM model: logs each accepted write, acks after ack_delay cycles of mem_wr.
    always @(posedge clk_50) begin
        if (load_done) done_cnt++;
        #2;
        if (mem_wr) begin
            if (ack_cnt >= ack_delay) begin
                mem_ack = 1'b1;
                wa.push_back(mem_addr);
                wd.push_back(mem_data);
                ack_cnt = 0;
            end else begin
                mem_ack = 1'b0;
                ack_cnt++;
            end
        end else begin
            mem_ack = 1'b0;
            ack_cnt = 0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk_50);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_wr(input string tag, input int k, input logic [15:0] a, input logic [7:0] d);
        logic [23:0] obs;
        obs = (k < wa.size()) ? {wa[k], wd[k]} : 24'hxxxxxx;
        chk(tag, 32'(obs), 32'({a, d}));
    endtask

    task automatic send_byte(input logic [7:0] b);
        ioctl_dout = b;
        ioctl_wr   = 1'b1;
        tick();
        ioctl_wr   = 1'b0;
    endtask

    task automatic send_data(input logic [7:0] b);
        int n;
        n = 0;
        while (ioctl_wait && n < 50) begin
            tick();
            n++;
        end
        if (ioctl_wait) chk("wait_timeout", 32'(ioctl_wait), 32'd0);
        send_byte(b);
    endtask

    task automatic start_load(input logic [7:0] idx);
        ioctl_index    = idx;
        ioctl_download = 1'b1;
        tick();
    endtask

    task automatic send_hdr(input logic [31:0] magic, input logic [7:0] typ,
                            input logic [15:0] st, input int n);
        logic [7:0] b;
        for (int i = 0; i < n; i++) begin
            if (i < 4)        b = magic[31-8*i -: 8];
            else if (i < 21)  b = 8'h41;
            else if (i == 21) b = typ;
            else if (i == 22) b = st[7:0];
            else              b = st[15:8];
            send_byte(b);
        end
    endtask

    task automatic finish_load();
        int n;
        ioctl_download = 1'b0;
        n = 0;
        tick();
        while (busy && n < 100) begin
            tick();
            n++;
        end
        if (busy) chk("busy_timeout", 32'(busy), 32'd0);
    endtask

    task automatic test1();
        base = wa.size();
        dbase = done_cnt;
        ack_delay = 2;
        start_load(8'h01);
        chk("t1_busy", 32'(busy), 32'd1);
        send_hdr(32'h565A4630, 8'hF1, 16'h8000, 24);
        chk("t1_mem_addr", 32'(mem_addr), 32'h8000);
        chk("t1_start", 32'(start_addr), 32'h8000);
        chk("t1_type", 32'(load_type), 32'hF1);
        send_data(8'hAA);
        send_data(8'hBB);
        send_data(8'hCC);
        finish_load();
        chk("t1_nwr", 32'(wa.size() - base), 32'd3);
        chk_wr("t1_wr0", base + 0, 16'h8000, 8'hAA);
        chk_wr("t1_wr1", base + 1, 16'h8001, 8'hBB);
        chk_wr("t1_wr2", base + 2, 16'h8002, 8'hCC);
        chk("t1_end", 32'(end_addr), 32'h8003);
        chk("t1_done", 32'(done_cnt - dbase), 32'd1);
        chk("t1_err", 32'(err), 32'd0);
        chk("t1_mem_wr", 32'(mem_wr), 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        ioctl_download = 1'b0;
        ioctl_index = 8'h00;
        ioctl_wr = 1'b0;
        ioctl_dout = 8'h00;
        mem_ack = 1'b0;
        tick();
        tick();
        chk("rst_mem_wr", 32'(mem_wr), 32'd0);
        chk("rst_wait", 32'(ioctl_wait), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(load_done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'd0);
        chk("rst_end", 32'(end_addr), 32'd0);
        reset = 1'b0;
        tick();

        test1();

        // BASIC image: pointer patched with end_addr 7AEB
        base = wa.size();
        dbase = done_cnt;
        ack_delay = 0;
        start_load(8'h01);
        send_hdr(32'h565A4630, 8'hF0, 16'h7AE9, 24);
        send_data(8'h11);
        send_data(8'h22);
        finish_load();
        chk("t2_nwr", 32'(wa.size() - base), 32'd4);
        chk_wr("t2_wr0", base + 0, 16'h7AE9, 8'h11);
        chk_wr("t2_wr1", base + 1, 16'h7AEA, 8'h22);
        chk_wr("t2_ptr_lo", base + 2, 16'h78F9, 8'hEB);
        chk_wr("t2_ptr_hi", base + 3, 16'h78FA, 8'h7A);
        chk("t2_end", 32'(end_addr), 32'h7AEB);
        chk("t2_done", 32'(done_cnt - dbase), 32'd1);

        // bad magic
        base = wa.size();
        dbase = done_cnt;
        start_load(8'h01);
        send_hdr(32'h41424330, 8'hF1, 16'h8000, 24);
        chk("t3_err_early", 32'(err), 32'b001);
        chk("t3_busy", 32'(busy), 32'd1);
        send_byte(8'h55);
        send_byte(8'h66);
        finish_load();
        chk("t3_nwr", 32'(wa.size() - base), 32'd0);
        chk("t3_done", 32'(done_cnt - dbase), 32'd0);
        chk("t3_err", 32'(err), 32'b001);

        // short header
        base = wa.size();
        dbase = done_cnt;
        start_load(8'h01);
        send_hdr(32'h565A4630, 8'hF1, 16'h8000, 10);
        ioctl_download = 1'b0;
        tick();
        chk("t4_err", 32'(err), 32'b010);
        chk("t4_busy", 32'(busy), 32'd0);
        tick();
        chk("t4_nwr", 32'(wa.size() - base), 32'd0);
        chk("t4_done", 32'(done_cnt - dbase), 32'd0);

        // strobe during wait, address wrap
        base = wa.size();
        dbase = done_cnt;
        ack_delay = 5;
        start_load(8'h01);
        send_hdr(32'h565A4630, 8'h00, 16'hFFFF, 24);
        chk("t5_err_clr", 32'(err), 32'd0);
        send_data(8'h5A);
        chk("t5_wait", 32'(ioctl_wait), 32'd1);
        send_byte(8'h77);
        chk("t5_err_wait", 32'(err), 32'b100);
        chk("t5_pend_data", 32'(mem_data), 32'h5A);
        send_data(8'hA5);
        finish_load();
        chk("t5_nwr", 32'(wa.size() - base), 32'd2);
        chk_wr("t5_wr0", base + 0, 16'hFFFF, 8'h5A);
        chk_wr("t5_wr1", base + 1, 16'h0000, 8'hA5);
        chk("t5_end", 32'(end_addr), 32'h0001);
        chk("t5_err", 32'(err), 32'b100);
        chk("t5_done", 32'(done_cnt - dbase), 32'd1);

        // reset mid-write, foreign index ignored, then normal load
        base = wa.size();
        dbase = done_cnt;
        ack_delay = 10;
        start_load(8'h01);
        send_hdr(32'h565A4630, 8'hF1, 16'h9000, 24);
        send_data(8'h12);
        chk("t6_mem_wr_pre", 32'(mem_wr), 32'd1);
        #3;
        reset = 1'b1;
        #1;
        chk("t6_mem_wr_rst", 32'(mem_wr), 32'd0);
        chk("t6_wait_rst", 32'(ioctl_wait), 32'd0);
        chk("t6_busy_rst", 32'(busy), 32'd0);
        ioctl_download = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        chk("t6_nwr_rst", 32'(wa.size() - base), 32'd0);
        start_load(8'h02);
        send_byte(8'h56);
        send_byte(8'h5A);
        send_byte(8'h46);
        chk("t6_idx_busy", 32'(busy), 32'd0);
        ioctl_download = 1'b0;
        tick();
        tick();
        chk("t6_idx_nwr", 32'(wa.size() - base), 32'd0);
        chk("t6_idx_done", 32'(done_cnt - dbase), 32'd0);

        test1();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
